// File: rtl/semaforo_pkg.sv
// Shared types and constants for the two-way traffic-light phase scheduler.
// Lamp vectors are {red, yellow, green}.
package semaforo_pkg;

    typedef enum logic [2:0] {
        StAVerde,
        StAAmarelo,
        StLimp1,
        StBVerde,
        StBAmarelo,
        StLimp2
    } estado_e;

    localparam logic [2:0] VERMELHO_L = 3'b100;
    localparam logic [2:0] AMARELO_L  = 3'b010;
    localparam logic [2:0] VERDE_L    = 3'b001;

    localparam logic [7:0] VERDE   = 8'd3;
    localparam logic [7:0] AMARELO = 8'd1;
    localparam logic [7:0] VERDE_B = 8'd2;
    localparam logic [7:0] LIMPEZA = 8'd1;

    localparam logic [1:0] CFG_T_VERDE_A = 2'd0;
    localparam logic [1:0] CFG_T_AMARELO = 2'd1;
    localparam logic [1:0] CFG_T_VERDE_B = 2'd2;
    localparam logic [1:0] CFG_T_LIMPEZA = 2'd3;

    // Duration register that times a given phase.
    function automatic logic [1:0] fase_dur_sel(input estado_e s);
        logic [1:0] sel;
        sel = CFG_T_LIMPEZA;
        unique case (s)
            StAVerde:             sel = CFG_T_VERDE_A;
            StAAmarelo, StBAmarelo: sel = CFG_T_AMARELO;
            StBVerde:             sel = CFG_T_VERDE_B;
            default:              sel = CFG_T_LIMPEZA;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/contador_fase.sv
// Loadable phase down-counter with zero flag; a load of 0 behaves like a load of 1.
module contador_fase #(
    parameter int unsigned     Width    = 8,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] dur_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (dur_i == '0) ? '0 : dur_i - Width'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= ResetVal;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/escalonador_semaforo.sv
// Two-way intersection phase scheduler with pedestrian-request truncation of A's green
// and a runtime-programmable duration register file.
module escalonador_semaforo
    import semaforo_pkg::*;
#(
    parameter int unsigned W         = 8,
    parameter int unsigned MIN_VERDE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bt,
    input  logic         cfg_we,
    input  logic [1:0]   cfg_sel,
    input  logic [W-1:0] cfg_data,
    output logic [2:0]   A,
    output logic [2:0]   B,
    output logic         ped_pend
);

    localparam logic [W-1:0] MinLim = W'(MIN_VERDE - 1);

    estado_e      state_q, state_d;
    logic [W-1:0] dur_q [4];
    logic [W-1:0] dur_d [4];
    logic [W-1:0] elapsed_q, elapsed_d;
    logic         ped_pend_q, ped_pend_d;
    logic         cnt_zero;
    logic         trunc;
    logic         load;
    logic [W-1:0] dur_load;

    // Config register file
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            dur_d[i] = dur_q[i];
        end
        if (cfg_we) begin
            dur_d[cfg_sel] = cfg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dur_q[CFG_T_VERDE_A] <= W'(VERDE);
            dur_q[CFG_T_AMARELO] <= W'(AMARELO);
            dur_q[CFG_T_VERDE_B] <= W'(VERDE_B);
            dur_q[CFG_T_LIMPEZA] <= W'(LIMPEZA);
        end else begin
            for (int i = 0; i < 4; i++) begin
                dur_q[i] <= dur_d[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StAVerde;
            elapsed_q  <= '0;
            ped_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            elapsed_q  <= elapsed_d;
            ped_pend_q <= ped_pend_d;
        end
    end

    assign trunc = (state_q == StAVerde) && ped_pend_q && (elapsed_q >= MinLim);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StAVerde:   if (cnt_zero || trunc) state_d = StAAmarelo;
            StAAmarelo: if (cnt_zero)          state_d = StLimp1;
            StLimp1:    if (cnt_zero)          state_d = StBVerde;
            StBVerde:   if (cnt_zero)          state_d = StBAmarelo;
            StBAmarelo: if (cnt_zero)          state_d = StLimp2;
            StLimp2:    if (cnt_zero)          state_d = StAVerde;
            default:                           state_d = StAVerde;
        endcase
    end

    // Entered phase latches the register value from before this edge's write.
    assign load     = (state_d != state_q);
    assign dur_load = dur_q[fase_dur_sel(state_d)];

    always_comb begin
        elapsed_d = '0;
        if (state_q == StAVerde && state_d == StAVerde) begin
            elapsed_d = (elapsed_q == '1) ? elapsed_q : elapsed_q + W'(1);
        end
    end

    // A new press on the serving edge keeps the request pending.
    assign ped_pend_d = bt | (ped_pend_q & ~(load && state_d == StBVerde));

    contador_fase #(
        .Width    (W),
        .ResetVal (W'(VERDE - 8'd1))
    ) u_contador (
        .clk_i  (clk),
        .rst_ni (rst),
        .load_i (load),
        .dur_i  (dur_load),
        .zero_o (cnt_zero)
    );

    // Output decode
    always_comb begin
        A = VERMELHO_L;
        B = VERMELHO_L;
        unique case (state_q)
            StAVerde:   A = VERDE_L;
            StAAmarelo: A = AMARELO_L;
            StBVerde:   B = VERDE_L;
            StBAmarelo: B = AMARELO_L;
            default: begin
                A = VERMELHO_L;
                B = VERMELHO_L;
            end
        endcase
    end

    assign ped_pend = ped_pend_q;

endmodule

// File: tb/tb_escalonador_semaforo.sv
// Random and scenario stimulus on two schedulers (MIN_VERDE 1 and 2) against a phase-level model.
module tb_escalonador_semaforo;

    logic       clk = 1'b0;
    logic       rst, bt, cfg_we;
    logic [1:0] cfg_sel;
    logic [7:0] cfg_data;
    logic [2:0] a_o [2];
    logic [2:0] b_o [2];
    logic       pend_o [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    escalonador_semaforo #(.W(8), .MIN_VERDE(1)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .bt       (bt),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .A        (a_o[0]),
        .B        (b_o[0]),
        .ped_pend (pend_o[0])
    );

    escalonador_semaforo #(.W(8), .MIN_VERDE(2)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .bt       (bt),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
        .A        (a_o[1]),
        .B        (b_o[1]),
        .ped_pend (pend_o[1])
    );

    // Phase-level reference: phase index, cycles remaining, cycles spent, pending flag.
    int mins    [2] = '{1, 2};
    int dur_idx [6] = '{0, 1, 3, 2, 1, 3};
    int lamp_a  [6] = '{1, 2, 4, 4, 4, 4};
    int lamp_b  [6] = '{4, 4, 4, 1, 2, 4};
    int m_p     [2];
    int m_rem   [2];
    int m_spent [2];
    int m_pend  [2];
    int m_dur   [2][4];

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_p[k]     = 0;
            m_rem[k]   = 3;
            m_spent[k] = 1;
            m_pend[k]  = 0;
            m_dur[k]   = '{3, 1, 2, 1};
        end
    endtask

    task automatic model_step(input logic r, input logic b, input logic we,
                              input logic [1:0] sel, input logic [7:0] d);
        bit leave;
        int np;
        int nd;
        if (!r) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            leave = (m_rem[k] == 1) ||
                    (m_p[k] == 0 && m_pend[k] != 0 && m_spent[k] >= mins[k]);
            np = leave ? (m_p[k] + 1) % 6 : m_p[k];
            m_pend[k] = (b || (m_pend[k] != 0 && !(leave && np == 3))) ? 1 : 0;
            if (leave) begin
                nd         = m_dur[k][dur_idx[np]];
                m_rem[k]   = (nd == 0) ? 1 : nd;
                m_spent[k] = 1;
            end else begin
                m_rem[k]--;
                m_spent[k]++;
            end
            m_p[k] = np;
            if (we) m_dur[k][sel] = int'(d);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("A[%0d]", k), a_o[k], lamp_a[m_p[k]]);
            check_eq($sformatf("B[%0d]", k), b_o[k], lamp_b[m_p[k]]);
            check_eq($sformatf("ped_pend[%0d]", k), pend_o[k], m_pend[k]);
            check_eq($sformatf("both_nonred[%0d]", k),
                     (a_o[k] != 3'b100 && b_o[k] != 3'b100) ? 1 : 0, 0);
        end
    endtask

    // Drive at the falling edge, step model on the rising edge, check at the next falling edge.
    task automatic cycle(input logic r, input logic b, input logic we,
                         input logic [1:0] sel, input logic [7:0] d);
        rst = r; bt = b; cfg_we = we; cfg_sel = sel; cfg_data = d;
        @(posedge clk);
        model_step(r, b, we, sel, d);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 2'd0, 8'd0);
    endtask

    // Idle until model 0 is in phase p (and, if last, in its final cycle).
    task automatic run_until(input int p, input bit last);
        for (int i = 0; i < 60; i++) begin
            if (m_p[0] == p && (!last || m_rem[0] == 1)) return;
            idle(1);
        end
        check_eq("run_until_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b0; bt = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = 8'd0;
        model_reset();
        @(negedge clk);

        // Reset and idle sequence
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        idle(18);

        // Pedestrian pulse early in A green
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        idle(1);
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
        idle(10);

        // Press on the edge that enters B green; next A green must be truncated
        run_until(2, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
        idle(12);

        // Reprogram B green while it runs; then zero-length yellow
        run_until(3, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 2'd2, 8'd5);
        idle(20);
        cycle(1'b1, 1'b0, 1'b1, 2'd1, 8'd0);
        idle(20);

        // Write A green, then reset in the middle of B yellow
        cycle(1'b1, 1'b0, 1'b1, 2'd0, 8'd7);
        run_until(4, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, 8'd0);
        idle(12);

        // Write on a phase-entry edge uses the old value
        run_until(5, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 2'd0, 8'd6);
        idle(16);

        // Button held high
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b0, 2'd0, 8'd0);
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0),
                  2'($urandom_range(0, 3)),
                  8'($urandom_range(0, 6)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
